// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles for dmem_arbiter.
// The master modport belongs to whoever starts the access.
interface dmem_req_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        gnt;
    logic        done;
    logic        err;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, done, err, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, done, err, rdata);
endinterface

interface dmem_mem_if;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        read;
    logic        write;

    modport master (output addr, wdata, read, write, input  rdata);
    modport slave  (input  addr, wdata, read, write, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported 64-bit data memory between the core (id 0) and the loader (id 1).
// Each transaction is granted, range/alignment-checked, issued as one strobe and answered with done.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 1024,
    parameter bit          RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_req_if.slave  core,
    dmem_req_if.slave  loader,
    dmem_mem_if.master mem,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;
    localparam logic        ID_CORE    = 1'b0;
    localparam logic        ID_LOADER  = 1'b1;

    state_e      state_q, state_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] cap_q, cap_d;
    logic [63:0] c_rdata_q, c_rdata_d;
    logic [63:0] l_rdata_q, l_rdata_d;

    logic        any_req;
    logic        pick_loader;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_err;

    // Winner selection: on a tie, round-robin flips away from the last grant.
    always_comb begin
        any_req = core.req | loader.req;
        if (core.req && loader.req) begin
            pick_loader = RR_EN ? (last_q == ID_CORE) : 1'b0;
        end else begin
            pick_loader = loader.req;
        end
        sel_we    = pick_loader ? loader.we    : core.we;
        sel_addr  = pick_loader ? loader.addr  : core.addr;
        sel_wdata = pick_loader ? loader.wdata : core.wdata;
        sel_err   = (sel_addr >= ADDR_LIMIT) || (sel_addr[2:0] != 3'b000);
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        err_d     = err_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cap_d     = cap_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d    = pick_loader ? ID_LOADER : ID_CORE;
                    last_d  = pick_loader ? ID_LOADER : ID_CORE;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cap_d   = (we_q || err_q) ? 64'd0 : mem.rdata;
                state_d = RESP;
            end
            RESP: begin
                if (!we_q) begin
                    if (id_q == ID_LOADER) begin
                        l_rdata_d = err_q ? 64'd0 : cap_q;
                    end else begin
                        c_rdata_d = err_q ? 64'd0 : cap_q;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high so an in-flight strobe never reaches memory.
    always_comb begin
        core.gnt     = 1'b0;
        core.done    = 1'b0;
        core.err     = 1'b0;
        loader.gnt   = 1'b0;
        loader.done  = 1'b0;
        loader.err   = 1'b0;
        mem.addr     = 64'd0;
        mem.wdata    = 64'd0;
        mem.read     = 1'b0;
        mem.write    = 1'b0;
        busy         = 1'b0;
        core.rdata   = c_rdata_q;
        loader.rdata = l_rdata_q;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    core.gnt   = any_req & ~pick_loader;
                    loader.gnt = any_req &  pick_loader;
                end
                ACCESS: begin
                    busy      = 1'b1;
                    mem.addr  = addr_q;
                    mem.wdata = wdata_q;
                    mem.read  = ~we_q & ~err_q;
                    mem.write =  we_q & ~err_q;
                end
                RESP: begin
                    busy        = 1'b1;
                    core.done   = (id_q == ID_CORE);
                    core.err    = (id_q == ID_CORE) & err_q;
                    loader.done = (id_q == ID_LOADER);
                    loader.err  = (id_q == ID_LOADER) & err_q;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= ID_CORE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= ID_LOADER;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            cap_q     <= 64'd0;
            c_rdata_q <= 64'd0;
            l_rdata_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            err_q     <= err_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cap_q     <= cap_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one round-robin instance and one fixed-priority instance
// share the same requester stimulus, each with its own behavioural memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        c_req, c_we, l_req, l_we;
    logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        busy0, busy1;

    dmem_req_if ci0 ();
    dmem_req_if li0 ();
    dmem_req_if ci1 ();
    dmem_req_if li1 ();
    dmem_mem_if m0 ();
    dmem_mem_if m1 ();

    assign ci0.req = c_req;  assign ci0.we = c_we;  assign ci0.addr = c_addr;  assign ci0.wdata = c_wdata;
    assign li0.req = l_req;  assign li0.we = l_we;  assign li0.addr = l_addr;  assign li0.wdata = l_wdata;
    assign ci1.req = c_req;  assign ci1.we = c_we;  assign ci1.addr = c_addr;  assign ci1.wdata = c_wdata;
    assign li1.req = l_req;  assign li1.we = l_we;  assign li1.addr = l_addr;  assign li1.wdata = l_wdata;

    logic [63:0] mem0 [1024];
    logic [63:0] mem1 [1024];
    assign m0.rdata = mem0[m0.addr[12:3]];
    assign m1.rdata = mem1[m1.addr[12:3]];
    always @(posedge clk) if (m0.write) mem0[m0.addr[12:3]] <= m0.wdata;
    always @(posedge clk) if (m1.write) mem1[m1.addr[12:3]] <= m1.wdata;

    dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .core(ci0), .loader(li0), .mem(m0), .busy(busy0)
    );
    dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .core(ci1), .loader(li1), .mem(m1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    // Runs one transaction on dut0 and reports cycle offsets (relative to request) and observed values.
    task automatic txn(input bit ld, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                       output int g, output int s, output int d, output bit rd, output bit wr,
                       output logic [63:0] saddr, output logic [63:0] swdata, output bit err,
                       output logic [63:0] rdata, output bit clash);
        g = -1; s = -1; d = -1; rd = 0; wr = 0; saddr = '0; swdata = '0; err = 0; rdata = '0; clash = 0;
        @(posedge clk); #1;
        if (ld) begin l_req = 1; l_we = we; l_addr = addr; l_wdata = wd; end
        else    begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; end
        for (int i = 0; i < 12 && d < 0; i++) begin
            @(negedge clk);
            if (g < 0 && (ld ? li0.gnt : ci0.gnt)) g = i;
            if (m0.read || m0.write) begin
                s = i; rd = m0.read; wr = m0.write; saddr = m0.addr; swdata = m0.wdata;
            end
            if ((ci0.gnt || li0.gnt) && (ci0.done || li0.done)) clash = 1;
            if (ld ? li0.done : ci0.done) begin d = i; err = ld ? li0.err : ci0.err; end
            @(posedge clk); #1;
            if (g >= 0) begin if (ld) l_req = 0; else c_req = 0; end
        end
        rdata = ld ? li0.rdata : ci0.rdata;
        checks++;
        if (d < 0) begin errors++; $display("FAIL txn_timeout no done for addr %h", addr); end
        c_req = 0; l_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; c_req = 1; l_req = 1; c_we = 1; l_we = 0; c_addr = 64'h8; l_addr = 64'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({ci0.gnt, li0.gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", {ci0.gnt, li0.gnt}); end
        checks++; if ({ci0.done, li0.done, ci0.err, li0.err} !== 4'b0) begin errors++; $display("FAIL rst_done_err got %b want 0000", {ci0.done, li0.done, ci0.err, li0.err}); end
        checks++; if ({m0.read, m0.write, busy0} !== 3'b000) begin errors++; $display("FAIL rst_strobe_busy got %b want 000", {m0.read, m0.write, busy0}); end
        checks++; if (m0.addr !== 64'd0 || m0.wdata !== 64'd0) begin errors++; $display("FAIL rst_mem_bus got %h/%h want 0/0", m0.addr, m0.wdata); end
        checks++; if (ci0.rdata !== 64'd0 || li0.rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", ci0.rdata, li0.rdata); end
        @(posedge clk); #1;
        c_req = 0; l_req = 0; reset = 0;
    endtask

    task automatic test_write_read();
        int g, s, d; bit rd, wr, err, clash; logic [63:0] sa, sw, rdt;
        txn(0, 1, 64'h10, 64'hDEADBEEFDEADBEEF, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (s - g != 1) begin errors++; $display("FAIL wr_strobe_latency got %0d want 1", s - g); end
        checks++; if (d - g != 2) begin errors++; $display("FAIL wr_done_latency got %0d want 2", d - g); end
        checks++; if ({rd, wr} !== 2'b01) begin errors++; $display("FAIL wr_strobe_kind got %b want 01", {rd, wr}); end
        checks++; if (sa !== 64'h10 || sw !== 64'hDEADBEEFDEADBEEF) begin errors++; $display("FAIL wr_mem_bus got %h/%h want 10/deadbeefdeadbeef", sa, sw); end
        checks++; if (err !== 1'b0 || clash !== 1'b0) begin errors++; $display("FAIL wr_err_clash got %b%b want 00", err, clash); end
        txn(0, 0, 64'h10, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if ({rd, wr} !== 2'b10 || sa !== 64'h10) begin errors++; $display("FAIL rd_strobe got %b addr %h want 10 addr 10", {rd, wr}, sa); end
        checks++; if (rdt !== 64'hDEADBEEFDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL rd_data got %h err %b want deadbeefdeadbeef err 0", rdt, err); end
        checks++; if (d - g != 2) begin errors++; $display("FAIL rd_done_latency got %0d want 2", d - g); end
    endtask

    task automatic test_errors();
        int g, s, d; bit rd, wr, err, clash; logic [63:0] sa, sw, rdt;
        txn(0, 0, 64'h2000, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (s != -1 || err !== 1'b1 || rdt !== 64'd0) begin errors++; $display("FAIL err_range got strobe@%0d err %b rdata %h want none 1 0", s, err, rdt); end
        txn(0, 0, 64'h10, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        txn(0, 1, 64'h2000, 64'h1, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (s != -1 || err !== 1'b1 || rdt !== 64'hDEADBEEFDEADBEEF) begin errors++; $display("FAIL err_write got strobe@%0d err %b rdata %h want none 1 deadbeefdeadbeef", s, err, rdt); end
        txn(0, 0, 64'h14, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (s != -1 || err !== 1'b1 || rdt !== 64'd0) begin errors++; $display("FAIL err_align got strobe@%0d err %b rdata %h want none 1 0", s, err, rdt); end
    endtask

    task automatic test_loader_bounds();
        int g, s, d; bit rd, wr, err, clash; logic [63:0] sa, sw, rdt;
        txn(1, 1, 64'h1FF8, 64'h5555555555555555, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (err !== 1'b0 || wr !== 1'b1 || sa !== 64'h1FF8) begin errors++; $display("FAIL ld_top_write got err %b wr %b addr %h want 0 1 1ff8", err, wr, sa); end
        txn(0, 0, 64'h1FF8, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (rdt !== 64'h5555555555555555 || err !== 1'b0) begin errors++; $display("FAIL ld_top_read got %h err %b want 5555555555555555 0", rdt, err); end
        txn(1, 1, 64'h0, 64'hAAAAAAAAAAAAAAAA, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        txn(1, 0, 64'h0, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (rdt !== 64'hAAAAAAAAAAAAAAAA || err !== 1'b0) begin errors++; $display("FAIL ld_zero_read got %h err %b want aaaaaaaaaaaaaaaa 0", rdt, err); end
        checks++; if (ci0.rdata !== 64'h5555555555555555) begin errors++; $display("FAIL core_rdata_hold got %h want 5555555555555555", ci0.rdata); end
    endtask

    task automatic test_reset_mid_access();
        int g, s, d; bit rd, wr, err, clash; logic [63:0] sa, sw, rdt; bit late_done;
        txn(0, 1, 64'h20, 64'h1234567890ABCDEF, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 64'h20; c_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        checks++; if (ci0.gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", ci0.gnt); end
        @(posedge clk); #1;
        c_req = 0; reset = 1;
        @(negedge clk);
        checks++; if ({m0.read, m0.write} !== 2'b00) begin errors++; $display("FAIL mid_strobe got %b want 00", {m0.read, m0.write}); end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy0); end
        late_done = ci0.done;
        repeat (3) begin @(negedge clk); late_done |= ci0.done; end
        checks++; if (late_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b want 0", late_done); end
        txn(0, 0, 64'h20, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (rdt !== 64'h1234567890ABCDEF) begin errors++; $display("FAIL mid_mem_kept got %h want 1234567890abcdef", rdt); end
    endtask

    task automatic test_reset_idle_and_pending();
        int g, s, d; bit rd, wr, err, clash; logic [63:0] sa, sw, rdt;
        int cg, cd, lg;
        txn(1, 1, 64'h10, 64'hFFFFFFFFFFFFFFFF, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0;
        txn(0, 0, 64'h10, 64'h0, g, s, d, rd, wr, sa, sw, err, rdt, clash);
        checks++; if (rdt !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL idle_rst_mem got %h want ffffffffffffffff", rdt); end
        cg = -1; cd = -1; lg = -1;
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 64'h10;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cg < 0 && ci0.gnt) cg = i;
            if (cd < 0 && ci0.done) cd = i;
            if (lg < 0 && li0.gnt) lg = i;
            @(posedge clk); #1;
            if (cg >= 0) c_req = 0;
            if (cg >= 0 && i == cg) begin l_req = 1; l_we = 0; l_addr = 64'h1FF8; end
            if (lg >= 0) l_req = 0;
        end
        checks++; if (cd - cg != 2) begin errors++; $display("FAIL pend_core_done got %0d want 2", cd - cg); end
        checks++; if (lg - cg != 3) begin errors++; $display("FAIL pend_ld_gnt got %0d want 3", lg - cg); end
        checks++; if (li0.rdata !== 64'h5555555555555555) begin errors++; $display("FAIL pend_ld_rdata got %h want 5555555555555555", li0.rdata); end
    endtask

    task automatic test_arbitration();
        int n0, n1; int cyc0 [4]; bit who0 [4]; int cyc1 [4]; bit who1 [4];
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin cyc0[k] = -1; cyc1[k] = -1; who0[k] = 0; who1[k] = 0; end
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0;
        c_req = 1; l_req = 1; c_we = 0; l_we = 0; c_addr = 64'h0; l_addr = 64'h8;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ci0.gnt || li0.gnt) begin if (n0 < 4) begin cyc0[n0] = i; who0[n0] = li0.gnt; end n0++; end
            if (ci1.gnt || li1.gnt) begin if (n1 < 4) begin cyc1[n1] = i; who1[n1] = li1.gnt; end n1++; end
        end
        @(posedge clk); #1; c_req = 0; l_req = 0;
        repeat (4) @(posedge clk);
        checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL arb_gnt_count got %0d/%0d want 4/4", n0, n1); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (who0[k] !== k[0] || cyc0[k] != 3 * k) begin errors++; $display("FAIL arb_rr_%0d got who %b cyc %0d want %b %0d", k, who0[k], cyc0[k], k[0], 3 * k); end
            checks++; if (who1[k] !== 1'b0 || cyc1[k] != 3 * k) begin errors++; $display("FAIL arb_fixed_%0d got who %b cyc %0d want 0 %0d", k, who1[k], cyc1[k], 3 * k); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem0[i] = 64'd0; mem1[i] = 64'd0; end
        reset = 1; c_req = 0; l_req = 0; c_we = 0; l_we = 0;
        c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;
        test_reset();
        test_write_read();
        test_errors();
        test_loader_bounds();
        test_reset_mid_access();
        test_reset_idle_and_pending();
        test_arbitration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
